// File: rtl/blockram_fifo_controller.sv
// Valid/ack request FIFO over an external 1-cycle-latency dual-port block RAM, with a show-ahead head/skid buffer.
// Optional BLOCKRAM_FIFO_BYPASS_EN: pushes into an empty pipeline skip the RAM and land directly in head/skid.
module blockram_fifo_controller #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET = 64,
    parameter int SET_PTR_WIDTH_IN_BITS = 6,
    localparam int BYTE_LEN_IN_BITS = 8,
    localparam int WRITE_MASK_LEN = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_in,
    input  logic                                 request_valid_in,
    output logic                                 issue_ack_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_out,
    output logic                                 request_valid_out,
    input  logic                                 issue_ack_in,
    output logic                                 port_A_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            port_A_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     port_A_access_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] port_A_write_entry_out,
    output logic                                 port_B_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            port_B_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     port_B_access_set_addr_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] port_B_read_entry_in,
    input  logic                                 port_B_read_valid_in,
    output logic [SET_PTR_WIDTH_IN_BITS+1:0]     count_out,
    output logic                                 full_out,
    output logic                                 empty_out
);
    localparam int CW = SET_PTR_WIDTH_IN_BITS + 2;
    localparam logic [SET_PTR_WIDTH_IN_BITS:0] RAM_FULL = (SET_PTR_WIDTH_IN_BITS + 1)'(NUM_SET);

    logic [SET_PTR_WIDTH_IN_BITS-1:0]     wr_ptr_q, wr_ptr_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     rd_ptr_q, rd_ptr_d;
    logic [SET_PTR_WIDTH_IN_BITS:0]       ram_count_q, ram_count_d;
    logic                                 inflight_q, inflight_d;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] head_q, head_d;
    logic                                 head_valid_q, head_valid_d;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] skid_q, skid_d;
    logic                                 skid_valid_q, skid_valid_d;

    logic       full;
    logic       push;
    logic       pop;
    logic       ret;
    logic       fetch;
    logic       bypass;
    logic       ram_write;
    logic [1:0] buffered;

    always_comb begin
        full      = (ram_count_q == RAM_FULL);
        push      = request_valid_in & reset_in & ~full;
        pop       = head_valid_q & issue_ack_in;
        ret       = port_B_read_valid_in & inflight_q;

        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (pop) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                head_valid_d = 1'b0;
            end
        end

        // Occupancy seen by the fetch decision is the post-pop buffer plus the read already in flight.
        buffered = {1'b0, head_valid_d} + {1'b0, skid_valid_d};
        fetch    = (ram_count_q != '0) && ((buffered + {1'b0, inflight_q}) < 2'd2);

        if (ret) begin
            if (!head_valid_d) begin
                head_d       = port_B_read_entry_in;
                head_valid_d = 1'b1;
            end else begin
                skid_d       = port_B_read_entry_in;
                skid_valid_d = 1'b1;
            end
        end

`ifdef BLOCKRAM_FIFO_BYPASS_EN
        bypass = push && (ram_count_q == '0) && !inflight_q && (!head_valid_d || !skid_valid_d);
        if (bypass) begin
            if (!head_valid_d) begin
                head_d       = request_in;
                head_valid_d = 1'b1;
            end else begin
                skid_d       = request_in;
                skid_valid_d = 1'b1;
            end
        end
`else
        bypass = 1'b0;
`endif

        ram_write = push & ~bypass;

        wr_ptr_d = wr_ptr_q;
        if (ram_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        ram_count_d = ram_count_q;
        if (ram_write && !fetch) begin
            ram_count_d = ram_count_q + 1'b1;
        end else if (!ram_write && fetch) begin
            ram_count_d = ram_count_q - 1'b1;
        end

        inflight_d = inflight_q;
        if (fetch) begin
            inflight_d = 1'b1;
        end else if (ret) begin
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            inflight_q   <= 1'b0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            inflight_q   <= inflight_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign issue_ack_out              = reset_in & ~full;
    assign full_out                   = full;
    assign request_out                = head_q;
    assign request_valid_out          = head_valid_q;

    assign port_A_access_en_out       = ram_write;
    assign port_A_write_en_out        = ram_write ? '1 : '0;
    assign port_A_access_set_addr_out = wr_ptr_q;
    assign port_A_write_entry_out     = request_in;

    assign port_B_access_en_out       = fetch;
    assign port_B_write_en_out        = '0;
    assign port_B_access_set_addr_out = rd_ptr_q;

    assign count_out = CW'(ram_count_q) + CW'(inflight_q) + CW'(head_valid_q) + CW'(skid_valid_q);
    assign empty_out = (count_out == '0);

endmodule

// File: tb/tb_blockram_fifo_controller.sv
// Directed bench for blockram_fifo_controller with a behavioural 1-cycle-latency block RAM.
// Expectations adapt to BLOCKRAM_FIFO_BYPASS_EN when that macro is defined for the build.
module tb_blockram_fifo_controller;

`ifdef BLOCKRAM_FIFO_BYPASS_EN
    localparam int   LAT     = 1;
    localparam logic VIA_RAM = 1'b0;
`else
    localparam int   LAT     = 3;
    localparam logic VIA_RAM = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset_in;
    logic [63:0] request_in;
    logic        request_valid_in;
    logic        issue_ack_out;
    logic [63:0] request_out;
    logic        request_valid_out;
    logic        issue_ack_in;
    logic        a_en;
    logic [7:0]  a_we;
    logic [5:0]  a_addr;
    logic [63:0] a_data;
    logic        b_en;
    logic [7:0]  b_we;
    logic [5:0]  b_addr;
    logic [63:0] rd_data;
    logic        rd_valid = 1'b0;
    logic [7:0]  count_out;
    logic        full_out;
    logic        empty_out;

    logic [63:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blockram_fifo_controller #(
        .SINGLE_ENTRY_SIZE_IN_BITS(64),
        .NUM_SET(64),
        .SET_PTR_WIDTH_IN_BITS(6)
    ) dut (
        .clk_in(clk),
        .reset_in(reset_in),
        .request_in(request_in),
        .request_valid_in(request_valid_in),
        .issue_ack_out(issue_ack_out),
        .request_out(request_out),
        .request_valid_out(request_valid_out),
        .issue_ack_in(issue_ack_in),
        .port_A_access_en_out(a_en),
        .port_A_write_en_out(a_we),
        .port_A_access_set_addr_out(a_addr),
        .port_A_write_entry_out(a_data),
        .port_B_access_en_out(b_en),
        .port_B_write_en_out(b_we),
        .port_B_access_set_addr_out(b_addr),
        .port_B_read_entry_in(rd_data),
        .port_B_read_valid_in(rd_valid),
        .count_out(count_out),
        .full_out(full_out),
        .empty_out(empty_out)
    );

    always @(posedge clk) begin
        if (a_en) begin
            for (int b = 0; b < 8; b++) begin
                if (a_we[b]) mem[a_addr][b*8 +: 8] <= a_data[b*8 +: 8];
            end
        end
        rd_valid <= b_en;
        if (b_en) rd_data <= mem[b_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(output int t);
        t = 1;
        while (!request_valid_out && t < 10) begin
            step();
            t++;
        end
    endtask

    initial begin
        int t;
        int exp_v;
        int rx;
        int gaps;
        reset_in         = 1'b0;
        request_valid_in = 1'b1;
        request_in       = 64'hFFFF_FFFF_0000_0000;
        issue_ack_in     = 1'b1;

        // Reset held with a pending push
        repeat (3) step();
        check("rst_ack", issue_ack_out, 0);
        check("rst_empty", empty_out, 1);
        check("rst_count", count_out, 0);
        check("rst_full", full_out, 0);
        check("rst_vout", request_valid_out, 0);
        check("rst_rout", request_out, 0);
        check("rst_a_en", a_en, 0);
        check("rst_b_en", b_en, 0);
        check("rst_b_we", b_we, 0);

        reset_in = 1'b1;
        #1;
        check("rel_ack", issue_ack_out, 1);
        check("push_a_en", a_en, VIA_RAM);
        check("push_a_we", a_we, VIA_RAM ? 8'hFF : 8'h00);
        check("push_a_addr", a_addr, 0);
        step();
        request_valid_in = 1'b0;
        check("n1_count", count_out, 1);
        check("n1_b_en", b_en, VIA_RAM);
        wait_valid(t);
        check("first_latency", t, LAT);
        check("first_data", request_out, 64'hFFFF_FFFF_0000_0000);
        step();
        check("pop_empty", empty_out, 1);
        check("pop_vout", request_valid_out, 0);
        issue_ack_in = 1'b0;

        // Fill to capacity
        for (int i = 0; i < 66; i++) begin
            request_valid_in = 1'b1;
            request_in       = 64'(i);
            #1;
            check("fill_ack", issue_ack_out, 1);
            step();
        end
        request_valid_in = 1'b0;
        repeat (3) step();
        check("full_flag", full_out, 1);
        check("full_count", count_out, 66);
        check("full_ack", issue_ack_out, 0);

        // Push and pop together while full: push rejected, pop accepted
        request_valid_in = 1'b1;
        request_in       = 64'd66;
        issue_ack_in     = 1'b1;
        #1;
        check("pp_vout", request_valid_out, 1);
        check("pp_head", request_out, 0);
        check("pp_ack", issue_ack_out, 0);
        step();
        request_valid_in = 1'b0;
        check("pp_count", count_out, 65);
        check("pp_full", full_out, 0);

        exp_v = 1;
        for (int c = 0; c < 300 && exp_v < 66; c++) begin
            if (request_valid_out) begin
                check("drain", request_out, 64'(exp_v));
                exp_v++;
            end
            step();
        end
        check("drain_total", exp_v, 66);
        check("drain_empty", empty_out, 1);
        check("drain_count", count_out, 0);

        // Streaming with continuous pop, wrapping both pointers
        rx   = 0;
        gaps = 0;
        for (int c = 0; c < 300 && rx < 200; c++) begin
            request_valid_in = (c < 200);
            request_in       = 64'h1000 + 64'(c);
            if (request_valid_out) begin
                check("stream", request_out, 64'h1000 + 64'(rx));
                rx++;
            end else if (rx > 0) begin
                gaps++;
            end
            step();
        end
        request_valid_in = 1'b0;
        check("stream_total", rx, 200);
        check("stream_gaps", gaps, 0);
        check("stream_empty", empty_out, 1);

        // Reset with entries queued and a RAM read in flight
        issue_ack_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            request_valid_in = 1'b1;
            request_in       = 64'h2000 + 64'(i);
            step();
        end
        request_valid_in = 1'b0;
        repeat (3) step();
        check("q10_count", count_out, 10);
        issue_ack_in = 1'b1;
        #1;
        check("q10_fetch", b_en, 1);
        step();
        issue_ack_in = 1'b0;
        check("q10_popped", count_out, 9);
        reset_in = 1'b0;
        #1;
        check("mid_rst_vout", request_valid_out, 0);
        check("mid_rst_rout", request_out, 0);
        check("mid_rst_count", count_out, 0);
        check("mid_rst_empty", empty_out, 1);
        check("mid_rst_ack", issue_ack_out, 0);
        check("mid_rst_b_en", b_en, 0);
        #3;
        reset_in = 1'b1;
        step();
        check("stale_ret_vout", request_valid_out, 0);
        check("stale_ret_count", count_out, 0);

        request_valid_in = 1'b1;
        request_in       = 64'hA5A5_A5A5_A5A5_A5A5;
        step();
        request_valid_in = 1'b0;
        issue_ack_in     = 1'b1;
        wait_valid(t);
        check("a5_latency", t, LAT);
        check("a5_data", request_out, 64'hA5A5_A5A5_A5A5_A5A5);
        step();
        check("a5_empty", empty_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blockram_fifo_controller.md
# blockram_fifo_controller

Synchronous FIFO controller that fronts a `dual_port_blockram` instance and turns it into a valid/ack request queue. Port A is used write-only for enqueue and port B read-only for dequeue. A two-entry output buffer hides the RAM's one-cycle read latency, so the consumer sees a show-ahead head entry. The block sits between a request producer and a request consumer in the memory subsystem and owns all pointer and occupancy bookkeeping.

## Interface
- `SINGLE_ENTRY_SIZE_IN_BITS`, 64: entry width; must equal the RAM's parameter.
- `NUM_SET`, 64: RAM depth; power of two.
- `SET_PTR_WIDTH_IN_BITS`, 6: log2(`NUM_SET`).
- `WRITE_MASK_LEN`, `SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS`: RAM byte-mask width; derived, not overridden.

Ports:
- `clk_in` in 1: single clock; all state on rising edge.
- `reset_in` in 1: asynchronous, active-low reset.
- `request_in` in `SINGLE_ENTRY_SIZE_IN_BITS`: enqueue data.
- `request_valid_in` in 1: enqueue request.
- `issue_ack_out` out 1: enqueue accepted this cycle when high together with `request_valid_in`.
- `request_out` out `SINGLE_ENTRY_SIZE_IN_BITS`: head entry.
- `request_valid_out` out 1: head entry valid.
- `issue_ack_in` in 1: consumer pops the head when high together with `request_valid_out`.
- `port_A_access_en_out`, `port_A_write_en_out[WRITE_MASK_LEN]`, `port_A_access_set_addr_out[SET_PTR_WIDTH_IN_BITS]`, `port_A_write_entry_out`: RAM write port.
- `port_B_access_en_out`, `port_B_write_en_out[WRITE_MASK_LEN]`, `port_B_access_set_addr_out[SET_PTR_WIDTH_IN_BITS]`: RAM read port. `port_B_write_en_out` is tied to all-zero.
- `port_B_read_entry_in` in `SINGLE_ENTRY_SIZE_IN_BITS`, `port_B_read_valid_in` in 1: RAM read return.
- `count_out` out `SET_PTR_WIDTH_IN_BITS+2`: total occupancy (RAM + in-flight + output buffer).
- `full_out`, `empty_out` out 1: RAM-region full; total occupancy zero.

## Operation
- State:
  - `wr_ptr` and `rd_ptr` (`SET_PTR_WIDTH_IN_BITS` bits each).
  - `ram_count` (0..`NUM_SET`).
  - `inflight` (0/1).
  - Output buffer `head`/`skid` with valid bits.
- Push (`request_valid_in & issue_ack_out`):
  - Port A access enabled, mask all-ones, address `wr_ptr`, data `request_in`.
  - `wr_ptr` increments, wrapping `NUM_SET-1`→0.
  - `ram_count` increments.
- `issue_ack_out` = `~full_out`, where `full_out` = (`ram_count == NUM_SET`). It is registered-state based; a same-cycle pop does not free a slot for a push.
- Fetch: issue a port B read at `rd_ptr` when `ram_count != 0` and (buffered entries + `inflight`, after this cycle's pop) < 2.
  - On fetch, `rd_ptr` increments (wrapping), `ram_count` decrements and `inflight` is set.
  - Port B is otherwise idle (`access_en` = 0).
- Return: a cycle with `port_B_read_valid_in` captures `port_B_read_entry_in` into `head` if `head` is empty or popping; otherwise into `skid`. `inflight` clears.
- Pop: `skid` moves to `head` and is emptied. If `skid` is empty, `head` is invalidated, unless a return is captured that cycle.
- Simultaneous push and fetch on the same address cannot occur: a fetch only targets entries written in an earlier cycle.
- `count_out` = `ram_count + inflight + head_valid + skid_valid`; the maximum is `NUM_SET+2`.
- `empty_out` = (`count_out == 0`).
- Reset mid-operation: all pointers, counts and valid bits clear immediately and the queue is lost. An outstanding RAM return arriving after reset release is ignored, because `inflight` is 0.

## Timing
- Reset values:
  - `request_valid_out` = 0, `request_out` = 0, `count_out` = 0, `empty_out` = 1, `full_out` = 0.
  - All port_A/port_B enables and addresses = 0.
  - `issue_ack_out` = 0 while `reset_in` is low, 1 after release.
- Push in cycle N (empty FIFO, no bypass):
  - Fetch in N+1.
  - `port_B_read_valid_in` in N+2.
  - `request_valid_out` high in N+3.
- Steady-state throughput is one push and one pop per cycle with no bubbles once `head` and `skid` are primed.
- `request_out` and `request_valid_out` are held stable until popped.

## Configuration
- `BLOCKRAM_FIFO_BYPASS_EN` defined:
  - A push when `ram_count == 0`, `inflight == 0` and `head` is empty (or popping with `skid` empty) writes `request_in` directly into `head`. Port A is not accessed, and `request_valid_out` rises in N+1.
  - A push when only `skid` is empty and `ram_count == 0 && !inflight` fills `skid` directly.
- Undefined: every push goes through the RAM, giving 3-cycle latency as in Timing.

## Test plan
- Reset with `request_valid_in = 1` held -> `issue_ack_out = 0`, `empty_out = 1`, `count_out = 0` until release; first push accepted the cycle after release.
- Push 0xFFFFFFFF00000000 into an empty FIFO, consumer ack held high -> `request_out` = 0xFFFFFFFF00000000 at N+3 (N+1 with `BYTE_LEN` bypass macro `BLOCKRAM_FIFO_BYPASS_EN`), `empty_out` returns to 1 the cycle after the pop.
- Push 66 distinct values with `issue_ack_in = 0` -> `full_out = 1`, `count_out = 66`, `issue_ack_out = 0`; 67th value rejected; drain returns values 0..65 in order.
- Push 200 incrementing values with continuous pop -> output is in order with no gaps after the first valid; `wr_ptr`/`rd_ptr` wrap three times without loss.
- Full FIFO, push and pop in the same cycle -> push rejected, pop accepted, `count_out` = 65, `full_out` deasserts only after the next fetch.
- Assert reset with 10 entries queued and a read in flight -> all outputs return to reset values immediately; a subsequent push of 0xA5A5A5A5A5A5A5A5 is the first value delivered.
